onchip_memory_pipelined: RTL
============================

ONCHIP_MEMORY_PIPELINED -- requirements
Module: onchip_memory_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, meaning word address width.
REQ-003 SHALL have parameter DEPTH, default 25000, meaning number of words implemented, at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning clocks from read accept to readdatavalid; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_FILE, default "onchip_memory_pipelined.hex", meaning the power-up contents file.
REQ-006 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all logic rising-edge.
  reset  in  1  asynchronous, active-high reset.
  reset_req  in  1  memory clock-enable kill during reset sequencing.
  clken  in  1  global clock enable; 0 stalls the entire block.
  chipselect  in  1  slave select.
  read  in  1  read strobe.
  write  in  1  write strobe.
  address  in  ADDR_WIDTH  word address.
  byteenable  in  DATA_WIDTH/8  byte lanes.
  writedata  in  DATA_WIDTH  write data.
  readdata  out  DATA_WIDTH  read data.
  readdatavalid  out  1  readdata qualifier, one pulse per accepted read.
  range_err  out  1  sticky flag: an access hit address >= DEPTH.
  parity_err  out  1  parity mismatch on a returned read; present only under the macro.

Function
REQ-007 SHALL define enable as clken AND NOT reset_req; when enable=0, SHALL accept no access, SHALL freeze memory, pipeline and flags, and SHALL hold all outputs.
REQ-008 SHALL accept a write when enable, chipselect and write are 1, updating only lanes with byteenable=1, visible to any read accepted on a later edge.
REQ-009 SHALL accept a read when enable, chipselect and read are 1 and write is 0; read=1 together with write=1 SHALL be treated as a write only.
REQ-010 SHALL never assert waitrequest; it accepts one access per enabled clock, fully pipelined.
REQ-011 SHALL assert readdatavalid for one enabled clock exactly READ_LATENCY enabled clocks after each accepted read, with readdata valid in that clock.
REQ-012 With READ_LATENCY=2, SHALL register the memory output once more; back-to-back reads SHALL produce back-to-back readdatavalid pulses in order.
REQ-013 A read on the clock after a write to the same address SHALL return the new data.
REQ-014 SHALL drop a write with address >= DEPTH, leaving memory unchanged, and SHALL set range_err.
REQ-015 SHALL complete a read with address >= DEPTH normally (readdatavalid per REQ-011) with readdata all-zero, and SHALL set range_err.
REQ-016 range_err SHALL stay 1 until reset; there is no software clear.
REQ-017 Outside readdatavalid cycles, readdata SHALL hold its last value.

Reset
REQ-018 On reset=1, asynchronously: readdatavalid=0, readdata=0, range_err=0, parity_err=0, read pipeline flushed.
REQ-019 Reads in flight at reset assertion SHALL be discarded and SHALL never produce readdatavalid.
REQ-020 Memory contents SHALL NOT be cleared by reset; INIT_FILE applies at configuration only.

Configuration
REQ-021 Macro ONCHIP_MEMORY_PIPELINED_PARITY_EN defined: store one even-parity bit per byte; on each readdatavalid, recompute parity over in-range data; any mismatch sets sticky parity_err, cleared only by reset.
REQ-022 Macro undefined: no parity storage or check; parity_err SHALL be tied to 0.

Verification
REQ-023 Write 0xDEADBEEF to addr 5 with byteenable=0xF, then byteenable=0x2 with 0x00001200 -> read addr 5 returns 0xDEAD12EF.
REQ-024 READ_LATENCY=2, reads to addr 0,1,2 on consecutive clocks -> readdatavalid high on clocks 2,3,4 with data in order.
REQ-025 Write addr 25000 with 0x12345678 -> range_err=1, addr 0 unchanged; read addr 25000 -> readdata=0x0.
REQ-026 Read accepted, then clken=0 for 3 clocks -> readdatavalid deferred by exactly 3 clocks, data intact.
REQ-027 Reset asserted one clock after a read accept -> no readdatavalid afterwards; readdata=0, range_err=0.
REQ-028 With PARITY_EN, force a stored data bit flip at addr 7 -> read addr 7 gives parity_err=1, held until reset.

Source files
------------

// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined
// Single-port on-chip RAM slave with a fixed-latency read pipeline. It never
// stalls the master and accepts one access per enabled clock.
//
// Parameters:
//   DATA_WIDTH   - data bus width in bits (multiple of 8)
//   ADDR_WIDTH   - word address width
//   DEPTH        - number of implemented words (<= 2**ADDR_WIDTH)
//   READ_LATENCY - 1 or 2 enabled clocks from read accept to readdatavalid
//   INIT_FILE    - power-up contents file name, consumed by the FPGA
//                  configuration flow; reset never touches the array
//
// Ports:
//   clk           - single rising-edge clock
//   reset         - asynchronous active-high reset (flushes reads, clears flags)
//   reset_req     - kills the clock enable while reset is being sequenced
//   clken         - global clock enable; 0 freezes the whole block
//   chipselect    - slave select
//   read, write   - access strobes (read with write counts as a write)
//   address       - word address
//   byteenable    - write byte lanes
//   writedata     - write data
//   readdata      - read data, holds its value outside readdatavalid
//   readdatavalid - one pulse per accepted read
//   range_err     - sticky: an access targeted address >= DEPTH
//   parity_err    - sticky parity mismatch on returned data
//
// Optional feature: define ONCHIP_MEMORY_PIPELINED_PARITY_EN to store one
// even-parity bit per byte and check it on every returned in-range read.
// Without the macro no parity is stored and parity_err is tied to 0.
module onchip_memory_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int DEPTH        = 25000,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "onchip_memory_pipelined.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    range_err,
  output logic                    parity_err
);

  localparam int LANES = DATA_WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  enable;
  logic                  in_range;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // Final pipeline stage inputs, feeding the output registers.
  logic                  fin_valid;
  logic [DATA_WIDTH-1:0] fin_data;

  assign enable   = clken & ~reset_req;
  assign in_range = ({1'b0, address} < DEPTH_LIMIT);
  assign wr_acc   = enable & chipselect & write;
  assign rd_acc   = enable & chipselect & read & ~write;
  // Out-of-range reads complete normally but return zero.
  assign rd_word  = in_range ? mem[address] : '0;

  // Byte-lane write into the array; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int b = 0; b < LANES; b++) begin
        if (byteenable[b]) begin
          mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
  logic [LANES-1:0] par_mem [0:DEPTH-1];
  logic [LANES-1:0] rd_par;
  logic [LANES-1:0] fin_par;
  logic             fin_chk;

  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [LANES-1:0] p;
    p = '0;
    for (int b = 0; b < LANES; b++) begin
      p[b] = ^d[b*8 +: 8];
    end
    return p;
  endfunction

  assign rd_par = in_range ? par_mem[address] : '0;

  // Parity bits follow the data lanes they protect.
  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int b = 0; b < LANES; b++) begin
        if (byteenable[b]) begin
          par_mem[address][b] <= ^writedata[b*8 +: 8];
        end
      end
    end
  end
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
      logic [LANES-1:0]      s1_par;
      logic                  s1_chk;
`endif

      // Extra register stage behind the array; it only advances on enabled
      // clocks so stalls defer the result without losing it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
          s1_par   <= '0;
          s1_chk   <= 1'b0;
`endif
        end else if (enable) begin
          s1_valid <= rd_acc;
          if (rd_acc) begin
            s1_data <= rd_word;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
            s1_par  <= rd_par;
            s1_chk  <= in_range;
`endif
          end
        end
      end

      assign fin_valid = s1_valid;
      assign fin_data  = s1_data;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
      assign fin_par   = s1_par;
      assign fin_chk   = s1_chk;
`endif
    end else begin : g_lat1
      assign fin_valid = rd_acc;
      assign fin_data  = rd_word;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
      assign fin_par   = rd_par;
      assign fin_chk   = in_range;
`endif
    end
  endgenerate

  // Output registers: readdata only reloads with a returned read, so it
  // holds its last value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else if (enable) begin
      readdatavalid <= fin_valid;
      if (fin_valid) begin
        readdata <= fin_data;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if ((wr_acc || rd_acc) && !in_range) begin
      range_err <= 1'b1;
    end
  end

`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
  // Parity is recomputed on the data being returned; zeroed out-of-range
  // results are excluded from the check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (enable && fin_valid && fin_chk &&
                 (lane_parity(fin_data) != fin_par)) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
